// File: rtl/maxpool2x2_relu_if.sv
// maxpool2x2_relu_if: AXI4-stream beat bundle shared by the pooling stage's input and output.
//   tvalid/tready : beat handshake
//   tdata         : LANES packed words
//   tlast         : end of image (driven by the master side only)
interface maxpool2x2_relu_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;
   modport master (output tvalid, tdata, tlast, input tready);
   modport slave (input tvalid, tdata, output tready);
endinterface

// File: rtl/maxpool2x2_relu.sv
// maxpool2x2_relu: streaming ReLU followed by 2x2 stride-2 signed max pooling.
//   i_aclk    : clock, rising edge
//   i_aresetn : asynchronous active-low reset
//   up        : input stream, BEATS_PER_PIXEL beats of LANES words per pixel, raster order
//   down      : pooled stream, same beat format, tlast on the final beat of an image
module maxpool2x2_relu #(
   parameter int IN_HEIGHT       = 4,
   parameter int IN_WIDTH        = 4,
   parameter int WORD_WIDTH      = 8,
   parameter int LANES           = 2,
   parameter int BEATS_PER_PIXEL = 4
) (
   input logic              i_aclk,
   input logic              i_aresetn,
   maxpool2x2_relu_if.slave  up,
   maxpool2x2_relu_if.master down
);
   localparam int DW    = LANES * WORD_WIDTH;
   localparam int BW    = BEATS_PER_PIXEL > 1 ? $clog2(BEATS_PER_PIXEL) : 1;
   localparam int CW    = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
   localparam int RW    = IN_HEIGHT > 1 ? $clog2(IN_HEIGHT) : 1;
   localparam int DEPTH = (IN_WIDTH / 2) * BEATS_PER_PIXEL;
   localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [BW-1:0] B_LAST = BW'(BEATS_PER_PIXEL - 1);
   localparam logic [CW-1:0] C_LAST = CW'(IN_WIDTH - 1);
   localparam logic [RW-1:0] R_LAST = RW'(IN_HEIGHT - 1);
   localparam logic [CW-1:0] C_OUT  = CW'(2 * (IN_WIDTH / 2) - 1);
   localparam logic [RW-1:0] R_OUT  = RW'(2 * (IN_HEIGHT / 2) - 1);

   logic [BW-1:0] b;
   logic [CW-1:0] c;
   logic [RW-1:0] r;
   logic [DW-1:0] colreg [BEATS_PER_PIXEL];
   logic [DW-1:0] rowbuf [DEPTH];
   logic [DW-1:0] v, m, res;
   logic [AW-1:0] ra;
   logic          acc, load;

   assign up.tready = !down.tvalid || down.tready;
   assign acc       = up.tvalid && up.tready;
   // Only odd-row, odd-column beats complete a 2x2 block; a trailing odd column/row
   // is even-indexed, so it never loads output and its buffer writes are overwritten
   // before they are ever read.
   assign load      = acc && c[0] && r[0];
   assign ra        = AW'(32'(c >> 1) * BEATS_PER_PIXEL + 32'(b));

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [WORD_WIDTH-1:0] x, vk, mk, cr, rb;
      assign x  = up.tdata[WORD_WIDTH*k +: WORD_WIDTH];
      assign cr = colreg[b][WORD_WIDTH*k +: WORD_WIDTH];
      assign rb = rowbuf[ra][WORD_WIDTH*k +: WORD_WIDTH];
      assign vk = x[WORD_WIDTH-1] ? '0 : x;
      assign mk = cr > vk ? cr : vk;
      assign v[WORD_WIDTH*k +: WORD_WIDTH]   = vk;
      assign m[WORD_WIDTH*k +: WORD_WIDTH]   = mk;
      assign res[WORD_WIDTH*k +: WORD_WIDTH] = rb > mk ? rb : mk;
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         b           <= '0;
         c           <= '0;
         r           <= '0;
         down.tvalid <= 1'b0;
         down.tdata  <= '0;
         down.tlast  <= 1'b0;
      end else begin
         if (acc) begin
            b <= b == B_LAST ? '0 : b + 1'b1;
            if (b == B_LAST) c <= c == C_LAST ? '0 : c + 1'b1;
            if (b == B_LAST && c == C_LAST) r <= r == R_LAST ? '0 : r + 1'b1;
         end
         if (load) begin
            down.tdata <= res;
            down.tlast <= r == R_OUT && c == C_OUT && b == B_LAST;
         end
         down.tvalid <= load || (down.tvalid && !down.tready);
      end
   end

   // Partial-maximum storage is never reset: each entry is written earlier in the
   // same image before it is read.
   always_ff @(posedge i_aclk) begin
      if (acc && !c[0]) colreg[b] <= v;
      if (acc && c[0] && !r[0]) rowbuf[ra] <= m;
   end
endmodule

// File: doc/maxpool2x2_relu.md
# maxpool2x2_relu

Streaming ReLU plus 2x2/stride-2 max-pooling stage that sits directly downstream of the 3x3 convolution engine. It consumes the convolver's output AXI4-stream, where each pixel arrives as BEATS_PER_PIXEL beats of LANES filter results. It emits one pooled pixel, in the same beat format, per 2x2 input block. Buffering is limited to one half-width row of partial maxima plus one column-pair register set.

## Interface
- IN_HEIGHT, 4: input feature-map height (rows delivered by the convolver).
- IN_WIDTH, 4: input feature-map width.
- WORD_WIDTH, 8: width of each value; two's-complement signed.
- LANES, 2: values per beat; equals the convolver's filters per output beat.
- BEATS_PER_PIXEL, 4: beats per pixel; equals FILTERS/LANES.

- i_aclk  in  1  clock; all state updates on the rising edge.
- i_aresetn  in  1  asynchronous, active-low reset.
- i_tvalid  in  1  input beat valid.
- o_tready  out  1  input beat accepted when i_tvalid && o_tready.
- i_tdata  in  LANES*WORD_WIDTH  input lanes; lane k = bits [WORD_WIDTH*k +: WORD_WIDTH].
- o_tvalid  out  1  pooled beat valid.
- i_tready  in  1  downstream ready.
- o_tdata  out  LANES*WORD_WIDTH  pooled lanes, same lane layout as the input.
- o_tlast  out  1  high on the last beat of the last pooled pixel of an image.

## Operation
- Input order: raster scan, row-major, pixel-major; within a pixel, beats b = 0..BEATS_PER_PIXEL-1 arrive in filter-group order.
- Position counters:
  - beat b, wraps at BEATS_PER_PIXEL;
  - column c, wraps at IN_WIDTH;
  - row r, wraps at IN_HEIGHT.
  - All three advance only on accepted beats. After the last beat of the image, all counters return to 0 and the next image starts with no idle cycle.
- ReLU per lane: v = (x < 0) ? 0 : x, signed compare on WORD_WIDTH bits.
- Column-pair register colreg[b], BEATS_PER_PIXEL x LANES words:
  - even c: colreg[b] <= v.
  - odd c: m = lanewise max(colreg[b], v).
- Row buffer rowbuf[c/2][b], (IN_WIDTH/2)*BEATS_PER_PIXEL entries of LANES words:
  - odd c, even r: rowbuf[c/2][b] <= m.
  - odd c, odd r: result = lanewise max(rowbuf[c/2][b], m); result is loaded into the output register.
- All max operations are signed. No growth in width; the output word width equals WORD_WIDTH.
- Odd IN_WIDTH: the beats of column IN_WIDTH-1 are accepted and discarded.
- Odd IN_HEIGHT: row IN_HEIGHT-1 is accepted and discarded.
- Outputs per image: floor(IN_HEIGHT/2) * floor(IN_WIDTH/2) pooled pixels, each BEATS_PER_PIXEL beats, emitted in raster order.
- o_tlast is set with the output load when all of the following hold:
  - r = 2*floor(IN_HEIGHT/2)-1;
  - c = 2*floor(IN_WIDTH/2)-1;
  - b = BEATS_PER_PIXEL-1.
- rowbuf and colreg contents are not reset. Every read of either is preceded by a write in the same image, so reset values are never observed.

## Timing
- Reset (asynchronous assert): o_tvalid=0, o_tdata=0, o_tlast=0; all counters = 0.
- Reset mid-image: the partial image is abandoned. The first beat accepted after release is treated as r=0, c=0, b=0.
- Single output register: o_tready = !o_tvalid || i_tready, combinational. This rule applies to every input beat, including beats that produce no output.
- Latency: a pooled beat is visible on o_tvalid/o_tdata one cycle after the accepting edge of the odd-row, odd-column input beat.
- o_tvalid clears on an output handshake unless a new load occurs on the same edge. On a simultaneous handshake and load, the register holds the new data and o_tvalid stays 1.
- While o_tvalid && !i_tready: o_tdata and o_tlast are held stable, and o_tready=0.
- Throughput: one beat per cycle in and out when i_tready stays high; no bubbles at row, pixel or image boundaries.

## Test plan
- 4x4, LANES=1, BEATS=1, input values 0..15 in raster order, i_tready=1 -> outputs 5, 7, 13, 15; o_tlast only with 15; each output 1 cycle after its trigger beat.
- 4x4, every input 8'hF0 (-16) -> four outputs of 0. Mixed block {-3, -7, -1, -128} -> 0. Block {-3, 2, -1, 1} -> 2.
- LANES=2, BEATS=2, 4x4: lane 0 = 4*r+c, lane 1 = 100-(4*r+c), beat 1 = beat 0 + 1 -> first pixel beat 0 = {5, 100}, beat 1 = {6, 101}. Confirms lane and beat independence.
- Backpressure: hold i_tready=0 from the first output for 5 cycles -> o_tready=0 and o_tdata stable at 5 throughout; on release, output stream and count are unchanged.
- 5x5, values 0..24 -> exactly four outputs 6, 8, 16, 18; column 4 and row 4 discarded; o_tlast with 18. The next image's first output is correct.
- Assert i_aresetn=0 asynchronously after 6 accepted beats, then send a full 4x4 image -> o_tvalid=0 during reset; after release, outputs 5, 7, 13, 15.
